// File: rtl/fft_pkg.sv
// Shared constants and encodings for the 32-point radix-2 FFT sequencer.
package fft_pkg;

  localparam int ADDRSIZE  = 5;
  localparam int NUMADDR   = 32;
  localparam int NUMSTAGES = 5;
  localparam int WORDSIZE  = 16;

  // Stage encodings as driven on stage_num.
  localparam logic [2:0] STAGE0 = 3'b000;
  localparam logic [2:0] STAGE1 = 3'b001;
  localparam logic [2:0] STAGE2 = 3'b010;
  localparam logic [2:0] STAGE3 = 3'b011;
  localparam logic [2:0] STAGE4 = 3'b100;

  // Controller state encoding.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [ADDRSIZE-1:0]  addr_t;
  typedef logic [NUMSTAGES-2:0] bf_idx_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, k) -> operand pair and
// twiddle index. For stage s the operand pair is split by span = 2^s: the
// group number k>>s lands above the inserted span bit and the in-group
// offset j = k & (span-1) below it; b differs from a only in that bit.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [2:0] stage,
  input  bf_idx_t    k,
  output addr_t      a,
  output addr_t      b,
  output addr_t      tw
);

  // Insert the span bit at position s and shift j up to form the twiddle index.
  always_comb begin
    a  = '0;
    b  = '0;
    tw = '0;
    case (stage)
      STAGE0: begin
        a  = {k, 1'b0};
        b  = {k, 1'b1};
        tw = '0;
      end
      STAGE1: begin
        a  = {k[3:1], 1'b0, k[0]};
        b  = {k[3:1], 1'b1, k[0]};
        tw = {1'b0, k[0], 3'b000};
      end
      STAGE2: begin
        a  = {k[3:2], 1'b0, k[1:0]};
        b  = {k[3:2], 1'b1, k[1:0]};
        tw = {1'b0, k[1:0], 2'b00};
      end
      STAGE3: begin
        a  = {k[3], 1'b0, k[2:0]};
        b  = {k[3], 1'b1, k[2:0]};
        tw = {1'b0, k[2:0], 1'b0};
      end
      STAGE4: begin
        a  = {1'b0, k};
        b  = {1'b1, k};
        tw = {1'b0, k};
      end
      default: begin
        a  = '0;
        b  = '0;
        tw = '0;
      end
    endcase
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Sequencer for the 32-point in-place FFT: walks 5 stages x 16 butterflies,
// drives the twiddle ROM and presents operand addresses aligned with ROM data.
//
// Handshake: an issue happens in any ISSUE cycle where bf_ready is high;
// rom_cs marks that cycle. One cycle later bf_valid is high with addr_a/addr_b
// and the ROM output; the consumer must take every bf_valid (no back-pressure
// after issue). Stalls (bf_ready low) hold all counters.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        bf_ready,
  output logic        rom_cs,
  output addr_t       rom_addr,
  output addr_t       addr_a,
  output addr_t       addr_b,
  output logic        bf_valid,
  output logic [2:0]  stage_num,
  output bf_idx_t     bf_count,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam bf_idx_t    K_LAST     = '1;

  logic [1:0] state;
  logic [2:0] stage;
  bf_idx_t    k;
  logic [7:0] drain_cnt;
  logic       issue;
  addr_t      gen_a;
  addr_t      gen_b;
  addr_t      gen_tw;

  fft_addr_gen u_addr_gen (
    .stage (stage),
    .k     (k),
    .a     (gen_a),
    .b     (gen_b),
    .tw    (gen_tw)
  );

  assign issue     = (state == S_ISSUE) && bf_ready;
  assign rom_cs    = issue;
  assign rom_addr  = issue ? gen_tw : '0;
  assign stage_num = stage;
  assign bf_count  = k;
  assign state_dbg = state;

  // Controller: stage/butterfly counters, drain gap and completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stage     <= STAGE0;
      k         <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            stage <= STAGE0;
            k     <= '0;
            busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bf_ready) begin
            k <= k + 1'b1;
            if (k == K_LAST) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            if (stage == STAGE4) begin
              state <= S_DONE;
            end else begin
              stage <= stage + 3'd1;
              state <= S_ISSUE;
            end
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          stage <= STAGE0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand addresses captured on the issue edge; bf_valid lines up with ROM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_a   <= '0;
      addr_b   <= '0;
      bf_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      bf_valid <= issue;
      done     <= (state == S_DONE);
      if (issue) begin
        addr_a <= gen_a;
        addr_b <= gen_b;
      end
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl. A per-cycle schedule is derived from
// the issue/stall/drain rules and the bf_ready pattern; operand pairs come
// from an arithmetic model and are matched in order through a queue.
module tb_fft_seq_ctrl;

  localparam int MAXC = 512;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bf_ready;
  logic       rom_cs;
  logic [4:0] rom_addr;
  logic [4:0] addr_a;
  logic [4:0] addr_b;
  logic       bf_valid;
  logic [2:0] stage_num;
  logic [3:0] bf_count;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int checks;
  int errors;

  bit rdy [MAXC];
  bit ecs [MAXC];
  bit eidx[MAXC];
  int est [MAXC];
  int ek  [MAXC];
  int etw [MAXC];
  logic [9:0] exp_q[$];

  fft_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bf_ready  (bf_ready),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .bf_valid  (bf_valid),
    .stage_num (stage_num),
    .bf_count  (bf_count),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference butterfly: plain arithmetic on span, group and offset.
  function automatic void ref_bf(input int s, input int k, output int a, output int b, output int tw);
    int span;
    int grp;
    int j;
    span = 1 << s;
    grp  = k / span;
    j    = k % span;
    a    = grp * 2 * span + j;
    b    = a + span;
    tw   = j * (1 << (4 - s));
  endfunction

  task automatic check_all_zero(input string tag);
    chk(tag, {rom_cs, rom_addr, addr_a, addr_b, bf_valid, stage_num, bf_count,
              busy, done, state_dbg}, 32'd0);
  endtask

  // mode: 0 always ready, 1 three-cycle stall at stage 2 k=6, 2 random ready.
  // abort_c > 0 stops driving after that cycle (caller then resets).
  task automatic run_transform(input bit hold, input int mode, input int abort_c, input bit glitch);
    int t;
    int done_c;
    int last_c;
    int obs_done;
    int nvalid;
    int a;
    int b;
    int tw;
    logic [9:0] e;
    for (int i = 0; i < MAXC; i++) begin
      rdy[i] = 1'b1; ecs[i] = 1'b0; eidx[i] = 1'b0;
      est[i] = 0; ek[i] = 0; etw[i] = 0;
    end
    if (mode == 1) begin
      rdy[47] = 1'b0; rdy[48] = 1'b0; rdy[49] = 1'b0;
    end else if (mode == 2) begin
      for (int i = 1; i < 300; i++) rdy[i] = ($urandom_range(0, 3) != 0);
    end
    exp_q.delete();
    t = 1;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 16; k++) begin
        while (!rdy[t]) begin
          eidx[t] = 1'b1; est[t] = s; ek[t] = k;
          t++;
        end
        ref_bf(s, k, a, b, tw);
        ecs[t] = 1'b1; eidx[t] = 1'b1; est[t] = s; ek[t] = k; etw[t] = tw;
        exp_q.push_back({a[4:0], b[4:0]});
        t++;
      end
      for (int d = 0; d < 4; d++) begin
        eidx[t] = 1'b1; est[t] = s; ek[t] = 0;
        t++;
      end
    end
    done_c   = t + 1;
    last_c   = (abort_c > 0) ? abort_c : done_c;
    obs_done = 0;
    nvalid   = 0;
    start    = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (!hold) start = glitch && (c == 30 || c == 31);
      bf_ready = rdy[c];
      #1;
      chk("rom_cs", rom_cs, ecs[c]);
      if (ecs[c]) chk("rom_addr", rom_addr, etw[c]);
      if (eidx[c]) begin
        chk("stage_num", stage_num, est[c]);
        chk("bf_count", bf_count, ek[c]);
      end
      chk("bf_valid", bf_valid, ecs[c-1]);
      if (bf_valid) begin
        nvalid++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("addr_pair", {addr_a, addr_b}, e);
        end else begin
          chk("valid_extra", bf_valid, 1'b0);
        end
      end
      chk("busy", busy, c < done_c);
      chk("done", done, c == done_c);
      if (done && obs_done == 0) obs_done = c;
    end
    if (abort_c == 0) begin
      chk("done_cycle", obs_done, done_c);
      chk("valid_total", nvalid, 80);
      chk("queue_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    bf_ready = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full run with bf_ready high and a stray start pulse mid-transform.
    run_transform(1'b0, 0, 0, 1'b1);
    @(negedge clk);
    // Three-cycle stall at stage 2 k=6; done moves out by three cycles.
    run_transform(1'b0, 1, 0, 1'b0);
    @(negedge clk);
    // Random back-pressure.
    run_transform(1'b0, 2, 0, 1'b0);
    @(negedge clk);
    run_transform(1'b0, 2, 0, 1'b0);
    @(negedge clk);

    // Abort inside stage 3, async reset must clear outputs before the next edge.
    run_transform(1'b0, 0, 68, 1'b0);
    chk("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    run_transform(1'b0, 0, 0, 1'b0);

    // start held high: back-to-back transforms.
    run_transform(1'b1, 0, 0, 1'b0);
    run_transform(1'b1, 2, 0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("idle_after_hold_busy", busy, 1'b0);
    chk("idle_after_hold_done", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
